// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Multiplies finish after MULT_LAT cycles; divides use 32 restoring steps plus one sign-fix cycle.
module muldiv_unit #(
  parameter int MULT_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isMult,
  input  logic        isDiv,
  input  logic        isSigned,
  input  logic        isMthi,
  input  logic        isMtlo,
  input  logic        isMfhi,
  input  logic        isMflo,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        stall
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      r_state;
  logic [3:0]  r_mcnt;
  logic [4:0]  r_step;
  logic [63:0] r_prod;
  logic [31:0] r_dvd;
  logic [31:0] r_dvs;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;

  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic        w_div_zero;
  logic        w_fix;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [32:0] w_trial;
  logic        w_ge;
  logic [31:0] w_diff;

  assign w_a_ext = isSigned ? {{32{A[31]}}, A} : {32'b0, A};
  assign w_b_ext = isSigned ? {{32{B[31]}}, B} : {32'b0, B};
  assign w_prod  = w_a_ext * w_b_ext;

  // A zero divisor skips the magnitude/sign handling so the raw result is LO=all-ones, HI=A.
  assign w_div_zero = (B == 32'd0);
  assign w_fix      = isSigned & ~w_div_zero;
  assign w_a_abs    = (w_fix && A[31]) ? (32'd0 - A) : A;
  assign w_b_abs    = (w_fix && B[31]) ? (32'd0 - B) : B;

  // The trial remainder is 33 bits wide so unsigned divisors above 2^31 compare correctly.
  assign w_trial = {r_rem, r_dvd[31]};
  assign w_ge    = (w_trial >= {1'b0, r_dvs});
  assign w_diff  = w_trial[31:0] - r_dvs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mcnt  <= 4'd0;
      r_step  <= 5'd0;
      r_prod  <= 64'd0;
      r_dvd   <= 32'd0;
      r_dvs   <= 32'd0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (isMult) begin
            r_prod  <= w_prod;
            r_mcnt  <= 4'(MULT_LAT);
            r_state <= S_MUL;
            r_busy  <= 1'b1;
          end else if (isDiv) begin
            r_dvd   <= w_a_abs;
            r_dvs   <= w_b_abs;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_step  <= 5'd0;
            r_neg_q <= w_fix & (A[31] ^ B[31]);
            r_neg_r <= w_fix & A[31];
            r_state <= S_DIV;
            r_busy  <= 1'b1;
          end else if (isMthi) begin
            r_hi <= A;
          end else if (isMtlo) begin
            r_lo <= A;
          end
        end
        S_MUL: begin
          if (r_mcnt == 4'd1) begin
            r_hi    <= r_prod[63:32];
            r_lo    <= r_prod[31:0];
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          r_mcnt <= r_mcnt - 4'd1;
        end
        S_DIV: begin
          r_rem <= w_ge ? w_diff : w_trial[31:0];
          r_quo <= {r_quo[30:0], w_ge};
          r_dvd <= {r_dvd[30:0], 1'b0};
          r_step <= r_step + 5'd1;
          if (r_step == 5'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          r_lo    <= r_neg_q ? (32'd0 - r_quo) : r_quo;
          r_hi    <= r_neg_r ? (32'd0 - r_rem) : r_rem;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign HI    = r_hi;
  assign LO    = r_lo;
  assign busy  = r_busy;
  assign stall = r_busy & (isMult | isDiv | isMthi | isMtlo | isMfhi | isMflo);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: multiply/divide results, busy/stall timing, reset and mthi/mtlo.
// Inputs change 1ns after the rising edge and outputs are sampled at that same point.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        isMult, isDiv, isSigned, isMthi, isMtlo, isMfhi, isMflo;
  logic [31:0] A, B;
  logic [31:0] HI, LO;
  logic        busy, stall;

  int total = 0;
  int passed = 0;
  int n;

  muldiv_unit #(.MULT_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .isMult(isMult), .isDiv(isDiv), .isSigned(isSigned),
    .isMthi(isMthi), .isMtlo(isMtlo), .isMfhi(isMfhi), .isMflo(isMflo),
    .A(A), .B(B), .HI(HI), .LO(LO), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clear_req();
    isMult = 0; isDiv = 0; isSigned = 0; isMthi = 0; isMtlo = 0; isMfhi = 0; isMflo = 0;
  endtask

  // Presents one request for a single accepting edge, then removes it.
  task automatic issue(input logic m, input logic d, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
    isMult = m; isDiv = d; isSigned = s; A = a; B = b;
    tick();
    clear_req();
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    clear_req();
    A = 0; B = 0; rst = 1;
    tick(); tick();
    rst = 0;
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'd0);

    // signed multiply -2 * 3
    isMult = 1; isSigned = 1; A = 32'hFFFF_FFFE; B = 32'd3;
    chk("mult_accept_stall", {31'b0, stall}, 32'd0);
    tick(); clear_req();
    wait_idle(n);
    chk("mult_busy_cycles", n, 32'd4);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    issue(1, 0, 0, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);

    issue(0, 1, 1, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_busy_cycles", n, 32'd33);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    issue(0, 1, 0, 32'd7, 32'd2);
    wait_idle(n);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    // mfhi held behind divu 100/7, then a mult follows with no gap
    issue(0, 1, 0, 32'd100, 32'd7);
    isMfhi = 1;
    n = 0;
    while (stall === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk("mfhi_stall_cycles", n, 32'd33);
    chk("mfhi_sees_hi", HI, 32'd2);
    chk("mfhi_sees_lo", LO, 32'd14);
    isMfhi = 0; isMult = 1; A = 32'd3; B = 32'd5;
    chk("queued_mult_no_stall", {31'b0, stall}, 32'd0);
    tick(); clear_req();
    chk("queued_mult_busy", {31'b0, busy}, 32'd1);
    wait_idle(n);
    chk("queued_mult_lo", LO, 32'd15);
    chk("queued_mult_hi", HI, 32'd0);

    issue(0, 1, 1, 32'd5, 32'd0);
    wait_idle(n);
    chk("divzero_cycles", n, 32'd33);
    chk("divzero_lo", LO, 32'hFFFF_FFFF);
    chk("divzero_hi", HI, 32'd5);

    issue(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("ovf_lo", LO, 32'h8000_0000);
    chk("ovf_hi", HI, 32'd0);

    // reset in the middle of a divide
    issue(0, 1, 0, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    isMfhi = 1;
    chk("midrst_stall", {31'b0, stall}, 32'd0);
    isMfhi = 0;
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    for (int i = 0; i < 40; i++) tick();
    chk("midrst_no_late_hi", HI, 32'd0);
    chk("midrst_no_late_lo", LO, 32'd0);

    isMtlo = 1; A = 32'h1234;
    tick(); clear_req();
    chk("mtlo_lo", LO, 32'h1234);
    chk("mtlo_busy", {31'b0, busy}, 32'd0);

    // mthi held while a multiply producing HI=1 is in flight
    issue(1, 0, 0, 32'h0001_0000, 32'h0001_0000);
    isMthi = 1; A = 32'hDEAD;
    chk("mthi_busy_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("mthi_hi_unchanged", HI, 32'd0);
    n = 0;
    while (stall === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk("mthi_stall_cycles", n, 32'd3);
    chk("mthi_after_mult_hi", HI, 32'd1);
    chk("mthi_after_mult_lo", LO, 32'd0);
    tick(); clear_req();
    chk("mthi_hi", HI, 32'hDEAD);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
